// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, Val2 generation, ALU, status register,
// branch target and the EX/MEM pipeline register.
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic [8:0]  controllerRes,
    input  logic [31:0] Val_Rn,
    input  logic [31:0] Val_Rm,
    input  logic        imm,
    input  logic [11:0] shift_operand,
    input  logic [23:0] Signed_imm_24,
    input  logic [3:0]  Dest,
    input  logic [1:0]  sel_src1,
    input  logic [1:0]  sel_src2,
    input  logic [31:0] MEM_fwd,
    input  logic [31:0] WB_fwd,
    output logic [3:0]  Sr,
    output logic        branch_taken,
    output logic [31:0] branch_addr,
    output logic [31:0] ALU_Res_q,
    output logic [31:0] Store_Val_q,
    output logic [3:0]  Dest_q,
    output logic        WB_EN_q,
    output logic        MEM_R_EN_q,
    output logic        MEM_W_EN_q
);

    typedef enum logic [3:0] {
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } exe_cmd_e;

    logic [3:0]  sr_q, sr_d;
    logic [31:0] op1, rm, val2, alu_res_d;
    logic [31:0] imm_ext;
    logic [63:0] imm_dbl, rm_dbl;
    logic [4:0]  rot_amt, sh_amt;
    logic [32:0] sum;
    logic        c_new, v_new;
    logic        mem_en;
    exe_cmd_e    cmd;

    assign mem_en = controllerRes[7] | controllerRes[6];
    assign cmd    = exe_cmd_e'(controllerRes[5:2]);

    always_comb begin
        case (sel_src1)
            2'b01:   op1 = MEM_fwd;
            2'b10:   op1 = WB_fwd;
            default: op1 = Val_Rn;
        endcase
        case (sel_src2)
            2'b01:   rm = MEM_fwd;
            2'b10:   rm = WB_fwd;
            default: rm = Val_Rm;
        endcase
    end

    // Rotations use a doubled word so a zero amount falls out as a pass-through.
    assign imm_ext = {24'b0, shift_operand[7:0]};
    assign rot_amt = {shift_operand[11:8], 1'b0};
    assign sh_amt  = shift_operand[11:7];
    assign imm_dbl = {imm_ext, imm_ext} >> rot_amt;
    assign rm_dbl  = {rm, rm} >> sh_amt;

    always_comb begin
        if (mem_en) begin
            val2 = {20'b0, shift_operand};
        end else if (imm) begin
            val2 = imm_dbl[31:0];
        end else begin
            case (shift_operand[6:5])
                2'b00:   val2 = rm << sh_amt;
                2'b01:   val2 = rm >> sh_amt;
                2'b10:   val2 = $unsigned($signed(rm) >>> sh_amt);
                default: val2 = rm_dbl[31:0];
            endcase
        end
    end

    always_comb begin
        sum       = '0;
        alu_res_d = '0;
        c_new     = sr_q[1];
        v_new     = sr_q[0];
        case (cmd)
            CMD_MOV: alu_res_d = val2;
            CMD_MVN: alu_res_d = ~val2;
            CMD_AND: alu_res_d = op1 & val2;
            CMD_ORR: alu_res_d = op1 | val2;
            CMD_EOR: alu_res_d = op1 ^ val2;
            CMD_ADD, CMD_ADC: begin
                sum       = {1'b0, op1} + {1'b0, val2}
                          + {32'b0, (cmd == CMD_ADC) & sr_q[1]};
                alu_res_d = sum[31:0];
                c_new     = sum[32];
                v_new     = (op1[31] == val2[31]) && (alu_res_d[31] != op1[31]);
            end
            CMD_SUB, CMD_SBC: begin
                sum       = {1'b0, op1} - {1'b0, val2}
                          - {32'b0, (cmd == CMD_SBC) & ~sr_q[1]};
                alu_res_d = sum[31:0];
                c_new     = ~sum[32];
                v_new     = (op1[31] != val2[31]) && (alu_res_d[31] != op1[31]);
            end
            default: alu_res_d = '0;
        endcase
        sr_d = {alu_res_d[31], (alu_res_d == 32'b0), c_new, v_new};
    end

    assign branch_taken = controllerRes[1];
    assign branch_addr  = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};
    assign Sr           = sr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q        <= '0;
            ALU_Res_q   <= '0;
            Store_Val_q <= '0;
            Dest_q      <= '0;
            WB_EN_q     <= 1'b0;
            MEM_R_EN_q  <= 1'b0;
            MEM_W_EN_q  <= 1'b0;
        end else begin
            ALU_Res_q   <= alu_res_d;
            Store_Val_q <= rm;
            Dest_q      <= Dest;
            WB_EN_q     <= controllerRes[8];
            MEM_R_EN_q  <= controllerRes[7];
            MEM_W_EN_q  <= controllerRes[6];
            if (controllerRes[0])
                sr_q <= sr_d;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: a bit-serial shifter and 64-bit ALU model
// predict each EX/MEM capture and the status register.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC, Val_Rn, Val_Rm, MEM_fwd, WB_fwd;
    logic [8:0]  controllerRes;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] Signed_imm_24;
    logic [3:0]  Dest;
    logic [1:0]  sel_src1, sel_src2;
    logic [3:0]  Sr;
    logic        branch_taken;
    logic [31:0] branch_addr, ALU_Res_q, Store_Val_q;
    logic [3:0]  Dest_q;
    logic        WB_EN_q, MEM_R_EN_q, MEM_W_EN_q;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .rst(rst), .PC(PC), .controllerRes(controllerRes),
        .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .imm(imm), .shift_operand(shift_operand),
        .Signed_imm_24(Signed_imm_24), .Dest(Dest), .sel_src1(sel_src1),
        .sel_src2(sel_src2), .MEM_fwd(MEM_fwd), .WB_fwd(WB_fwd), .Sr(Sr),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .ALU_Res_q(ALU_Res_q), .Store_Val_q(Store_Val_q), .Dest_q(Dest_q),
        .WB_EN_q(WB_EN_q), .MEM_R_EN_q(MEM_R_EN_q), .MEM_W_EN_q(MEM_W_EN_q)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] store;
        logic [3:0]  dest;
        logic [2:0]  ctl;
        logic        chk_alu;
        logic [3:0]  sr;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_sr;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [8:0] mk(input logic wb, input logic mr, input logic mw,
                                      input logic [3:0] cmd, input logic b, input logic s);
        return {wb, mr, mw, cmd, b, s};
    endfunction

    function automatic logic [31:0] m_val2(input logic [8:0] ctrl, input logic im,
                                           input logic [11:0] sh, input logic [31:0] r);
        logic [31:0] v;
        if (ctrl[7] || ctrl[6]) return {20'b0, sh};
        if (im) begin
            v = {24'b0, sh[7:0]};
            for (int i = 0; i < 2 * int'(sh[11:8]); i++) v = {v[0], v[31:1]};
            return v;
        end
        v = r;
        for (int i = 0; i < int'(sh[11:7]); i++) begin
            case (sh[6:5])
                2'b00:   v = {v[30:0], 1'b0};
                2'b01:   v = {1'b0, v[31:1]};
                2'b10:   v = {v[31], v[31:1]};
                default: v = {v[0], v[31:1]};
            endcase
        end
        return v;
    endfunction

    task automatic m_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sin, output logic [31:0] r, output logic [3:0] sout);
        longint ua, ub, full, sa, ss, k, lim;
        int     ia, ib;
        logic   c, v;
        ua = a; ub = b; ia = a; ib = b; sa = ia; k = 0;
        lim = 64'sd2147483647;
        c = sin[1]; v = sin[0]; r = '0;
        case (cmd)
            4'd1: r = b;
            4'd9: r = ~b;
            4'd6: r = a & b;
            4'd7: r = a | b;
            4'd8: r = a ^ b;
            4'd2, 4'd3: begin
                k    = (cmd == 4'd3 && sin[1]) ? 1 : 0;
                full = ua + ub + k;
                r    = full[31:0];
                c    = full[32];
                ss   = sa + longint'(ib) + k;
                v    = (ss > lim) || (ss < -lim - 1);
            end
            4'd4, 4'd5: begin
                k    = (cmd == 4'd5 && !sin[1]) ? 1 : 0;
                full = ua - ub - k;
                r    = full[31:0];
                c    = (ua >= ub + k);
                ss   = sa - longint'(ib) - k;
                v    = (ss > lim) || (ss < -lim - 1);
            end
            default: r = '0;
        endcase
        sout = {r[31], r == 32'b0, c, v};
    endtask

    task automatic issue(input logic r, input logic [8:0] ctrl, input logic [31:0] rn,
                         input logic [31:0] rmv, input logic im, input logic [11:0] sh,
                         input logic [3:0] d, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [31:0] memf, input logic [31:0] wbf,
                         input logic [31:0] pc, input logic [23:0] simm);
        exp_t              e;
        logic [31:0]       op1, rmf, v2, res;
        logic [3:0]        srn;
        logic signed [25:0] off;
        int                offi;
        rst = r; controllerRes = ctrl; Val_Rn = rn; Val_Rm = rmv; imm = im;
        shift_operand = sh; Dest = d; sel_src1 = s1; sel_src2 = s2;
        MEM_fwd = memf; WB_fwd = wbf; PC = pc; Signed_imm_24 = simm;
        #1;
        off  = {simm, 2'b00};
        offi = off;
        check("branch_taken", {31'b0, branch_taken}, {31'b0, ctrl[1]});
        check("branch_addr", branch_addr, pc + offi);
        op1 = (s1 == 2'b01) ? memf : (s1 == 2'b10) ? wbf : rn;
        rmf = (s2 == 2'b01) ? memf : (s2 == 2'b10) ? wbf : rmv;
        v2  = m_val2(ctrl, im, sh, rmf);
        m_alu(ctrl[5:2], op1, v2, m_sr, res, srn);
        if (r) begin
            e = '{alu: 32'b0, store: 32'b0, dest: 4'b0, ctl: 3'b0, chk_alu: 1'b1, sr: 4'b0};
        end else begin
            e = '{alu: res, store: rmf, dest: d, ctl: ctrl[8:6],
                  chk_alu: (ctrl != 9'b0), sr: ctrl[0] ? srn : m_sr};
        end
        m_sr = e.sr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.chk_alu) check("ALU_Res_q", ALU_Res_q, e.alu);
        check("Store_Val_q", Store_Val_q, e.store);
        check("Dest_q", {28'b0, Dest_q}, {28'b0, e.dest});
        check("ctl_q", {29'b0, WB_EN_q, MEM_R_EN_q, MEM_W_EN_q}, {29'b0, e.ctl});
        check("Sr", {28'b0, Sr}, {28'b0, e.sr});
    endtask

    task automatic op(input logic [8:0] ctrl, input logic [31:0] rn, input logic [31:0] rmv,
                      input logic im, input logic [11:0] sh);
        issue(1'b0, ctrl, rn, rmv, im, sh, 4'h3, 2'b00, 2'b00, 32'h0, 32'h0, 32'h40, 24'h0);
    endtask

    initial begin
        m_sr = '0;
        rst = 1'b1; controllerRes = '0; Val_Rn = '0; Val_Rm = '0; imm = 1'b0;
        shift_operand = '0; Dest = '0; sel_src1 = '0; sel_src2 = '0;
        MEM_fwd = '0; WB_fwd = '0; PC = '0; Signed_imm_24 = '0;

        issue(1'b1, 9'h0, 0, 0, 1'b0, 12'h0, 4'h0, 2'b00, 2'b00, 0, 0, 0, 24'h0);
        op(mk(1, 0, 0, 4'd2, 0, 1), 32'd5, 32'd7, 1'b0, 12'h000);            // ADD
        op(mk(1, 0, 0, 4'd4, 0, 1), 32'd3, 32'd5, 1'b0, 12'h000);            // SUB
        op(mk(0, 0, 0, 4'd4, 0, 1), 32'd5, 32'd5, 1'b0, 12'h000);            // CMP
        op(mk(1, 0, 0, 4'd1, 0, 0), 32'd0, 32'd0, 1'b1, 12'h1FF);            // MOV imm
        op(mk(1, 0, 0, 4'd1, 0, 0), 32'd0, 32'h8000_0000, 1'b0, 12'h240);    // ASR #4
        op(mk(1, 0, 0, 4'd3, 0, 1), 32'hFFFF_FFFF, 32'd0, 1'b0, 12'h000);    // ADC
        op(mk(1, 0, 0, 4'd3, 0, 0), 32'd1, 32'd1, 1'b0, 12'h000);            // ADC 1+1+C
        op(mk(1, 0, 0, 4'd2, 0, 1), 32'h7FFF_FFFF, 32'd1, 1'b0, 12'h000);    // overflow
        op(mk(1, 0, 0, 4'd5, 0, 1), 32'd10, 32'd3, 1'b0, 12'h000);           // SBC, C=0
        op(mk(1, 0, 0, 4'd1, 0, 0), 32'd0, 32'h8000_0001, 1'b0, 12'h0E0);    // ROR #1
        op(mk(1, 0, 0, 4'd9, 0, 1), 32'd0, 32'h0F0F_0F0F, 1'b0, 12'h080);    // MVN LSL #1
        op(9'h0, 32'h1234, 32'h5678, 1'b0, 12'h000);                        // bubble
        issue(1'b0, mk(0, 0, 0, 4'd0, 1, 0), 0, 0, 1'b0, 12'h0, 4'h0,
              2'b00, 2'b00, 0, 0, 32'h100, 24'hFFFFFE);                     // B back
        issue(1'b0, mk(1, 0, 0, 4'd2, 1, 1), 32'd2, 0, 1'b1, 12'h001, 4'h0,
              2'b00, 2'b00, 0, 0, 32'h200, 24'h000010);                     // B with S
        issue(1'b0, mk(1, 0, 0, 4'd2, 0, 0), 32'd99, 0, 1'b1, 12'h001, 4'h5,
              2'b01, 2'b00, 32'd10, 32'd0, 0, 24'h0);                       // fwd MEM
        issue(1'b0, mk(1, 1, 0, 4'd2, 0, 0), 32'h1000, 32'h7, 1'b1, 12'hABC, 4'h9,
              2'b00, 2'b00, 0, 0, 0, 24'h0);                                // LDR
        issue(1'b0, mk(0, 0, 1, 4'd2, 0, 0), 32'h2000, 32'h7, 1'b0, 12'h004, 4'hA,
              2'b10, 2'b10, 32'h11, 32'hDEAD_BEEF, 0, 24'h0);               // STR fwd WB

        for (int i = 0; i < 60; i++) begin
            issue(($urandom_range(0, 19) == 0), 9'($urandom), $urandom, $urandom,
                  1'($urandom), 12'($urandom), 4'($urandom), 2'($urandom), 2'($urandom),
                  $urandom, $urandom, $urandom, 24'($urandom));
        end

        issue(1'b1, mk(1, 0, 1, 4'd2, 1, 1), 32'd5, 32'd6, 1'b0, 12'h0, 4'hF,
              2'b00, 2'b00, 0, 0, 0, 24'h0);                                // reset mid-stream

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
